// File: rtl/unsaved_nios2_qsys_0_oci_dct_packer.sv
// unsaved_nios2_qsys_0_oci_dct_packer
//   Packs 2-bit compressed trace symbols into a 15-slot accumulator and hands
//   completed (or flushed) packets downstream through a one-entry valid/ready
//   output register. Symbols arriving while the accumulator is full and the
//   output register cannot take a packet are dropped and counted.
//   Optional build macro: OCI_DCT_TIMEOUT_EN adds an idle timer that forces a
//   flush of a partial packet after TIMEOUT idle cycles.
module unsaved_nios2_qsys_0_oci_dct_packer #(
    parameter int unsigned SYM_W   = 2,
    parameter int unsigned SLOTS   = 15,
    parameter int unsigned DROP_W  = 8,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [SYM_W-1:0]               sym_in,
    input  logic                           sym_valid,
    input  logic                           flush,
    output logic [SYM_W*SLOTS-1:0]         dct_buffer,
    output logic [$clog2(SLOTS+1)-1:0]     dct_count,
    output logic                           pkt_valid,
    input  logic                           pkt_ready,
    output logic [SYM_W*SLOTS-1:0]         pkt_data,
    output logic [$clog2(SLOTS+1)-1:0]     pkt_count,
    output logic [DROP_W-1:0]              drop_cnt,
    output logic                           overflow
);

    localparam int unsigned CNT_W = $clog2(SLOTS + 1);
    localparam int unsigned BUF_W = SYM_W * SLOTS;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FILL  = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t             state, state_next;
    logic               flush_pend, flush_pend_next;
    logic [BUF_W-1:0]   buf_next;
    logic [CNT_W-1:0]   cnt_next;
    logic               pkt_valid_next;
    logic [BUF_W-1:0]   pkt_data_next;
    logic [CNT_W-1:0]   pkt_count_next;
    logic [DROP_W-1:0]  drop_next;
    logic               out_free;
    logic               launch;
    logic               accept;
    logic               drop;
    logic               timeout_hit;

`ifdef OCI_DCT_TIMEOUT_EN
    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

    logic [TMR_W-1:0]   idle_tmr, idle_tmr_next;

    // Idle timer: counts cycles holding symbols with no new symbol arriving
    always_comb begin
        idle_tmr_next = idle_tmr;
        timeout_hit   = 1'b0;
        if (launch || sym_valid) begin
            idle_tmr_next = '0;
        end else if (state != S_EMPTY) begin
            idle_tmr_next = idle_tmr + TMR_W'(1);
        end
        if (idle_tmr_next == TMR_W'(TIMEOUT)) begin
            timeout_hit   = 1'b1;
            idle_tmr_next = '0;
        end
    end

    // Idle timer register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idle_tmr <= '0;
        end else begin
            idle_tmr <= idle_tmr_next;
        end
    end
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    // Next-state, accumulator, output-register and drop logic
    always_comb begin
        out_free        = !pkt_valid || pkt_ready;
        accept          = pkt_valid && pkt_ready;
        launch          = out_free &&
                          ((state == S_FULL) || (flush_pend && (state != S_EMPTY)));
        drop            = sym_valid && (state == S_FULL) && !launch;

        buf_next        = dct_buffer;
        cnt_next        = dct_count;
        pkt_valid_next  = pkt_valid;
        pkt_data_next   = pkt_data;
        pkt_count_next  = pkt_count;
        drop_next       = drop_cnt;
        state_next      = state;

        // Launch empties the accumulator first so a same-cycle symbol lands in slot 0
        if (launch) begin
            pkt_valid_next = 1'b1;
            pkt_data_next  = dct_buffer;
            pkt_count_next = dct_count;
            buf_next       = '0;
            cnt_next       = '0;
        end else if (accept) begin
            pkt_valid_next = 1'b0;
        end

        if (sym_valid && !drop) begin
            buf_next[int'(cnt_next) * SYM_W +: SYM_W] = sym_in;
            cnt_next = cnt_next + CNT_W'(1);
        end

        if (drop && (drop_cnt != '1)) begin
            drop_next = drop_cnt + DROP_W'(1);
        end

        // A pending flush with nothing left to send is dropped rather than kept
        flush_pend_next = (flush || timeout_hit || (flush_pend && !launch)) &&
                          (cnt_next != '0);

        // State tracks the fill level of the accumulator
        if (cnt_next == '0) begin
            state_next = S_EMPTY;
        end else if (cnt_next == CNT_W'(SLOTS)) begin
            state_next = S_FULL;
        end else begin
            state_next = S_FILL;
        end
    end

    // State, accumulator and output register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_EMPTY;
            flush_pend <= 1'b0;
            dct_buffer <= '0;
            dct_count  <= '0;
            pkt_valid  <= 1'b0;
            pkt_data   <= '0;
            pkt_count  <= '0;
            drop_cnt   <= '0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_next;
            flush_pend <= flush_pend_next;
            dct_buffer <= buf_next;
            dct_count  <= cnt_next;
            pkt_valid  <= pkt_valid_next;
            pkt_data   <= pkt_data_next;
            pkt_count  <= pkt_count_next;
            drop_cnt   <= drop_next;
            overflow   <= drop;
        end
    end

endmodule

// File: tb/tb_unsaved_nios2_qsys_0_oci_dct_packer.sv
// Testbench for unsaved_nios2_qsys_0_oci_dct_packer.
// A queue-based model tracks accumulator contents, the held packet and the
// drop counter; a compare process checks every output on each falling edge.
// Directed literal checks pin the model at key points.
module tb_unsaved_nios2_qsys_0_oci_dct_packer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  sym_in = '0;
    logic        sym_valid = 1'b0;
    logic        flush = 1'b0;
    logic        pkt_ready = 1'b0;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        pkt_valid;
    logic [29:0] pkt_data;
    logic [3:0]  pkt_count;
    logic [7:0]  drop_cnt;
    logic        overflow;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    unsaved_nios2_qsys_0_oci_dct_packer #(
        .SYM_W(2), .SLOTS(15), .DROP_W(8), .TIMEOUT(64)
    ) dut (
        .clk(clk), .reset_n(reset_n), .sym_in(sym_in), .sym_valid(sym_valid),
        .flush(flush), .dct_buffer(dct_buffer), .dct_count(dct_count),
        .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_data(pkt_data),
        .pkt_count(pkt_count), .drop_cnt(drop_cnt), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [29:0] pack(input logic [1:0] q[$]);
        logic [29:0] r;
        r = '0;
        for (int i = 0; i < q.size(); i++) r[2*i +: 2] = q[i];
        return r;
    endfunction

    // Behavioural model
    logic [1:0] m_acc[$];
    logic [1:0] m_pkt[$];
    bit m_hv = 0, m_fp = 0, m_ovf = 0;
    int m_drop = 0, m_idle = 0;
    bit m_launch, m_hit, m_dropped;
    int m_n;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_acc.delete(); m_pkt.delete();
            m_hv = 0; m_fp = 0; m_ovf = 0; m_drop = 0; m_idle = 0;
        end else begin
            m_n = m_acc.size();
            m_launch = (!m_hv || pkt_ready) && (m_n == 15 || (m_fp && m_n != 0));
            m_hit = 0;
            if (m_launch || sym_valid) m_idle = 0;
            else if (m_n != 0) m_idle++;
`ifdef OCI_DCT_TIMEOUT_EN
            if (m_idle == 64) begin m_hit = 1; m_idle = 0; end
`endif
            m_dropped = 0;
            if (m_launch) begin
                m_pkt = m_acc; m_hv = 1; m_acc.delete();
            end else if (m_hv && pkt_ready) begin
                m_hv = 0;
            end
            if (sym_valid) begin
                if (m_acc.size() < 15) m_acc.push_back(sym_in);
                else m_dropped = 1;
            end
            m_ovf = m_dropped;
            if (m_dropped && m_drop < 255) m_drop++;
            m_fp = (flush || m_hit || (m_fp && !m_launch)) && (m_acc.size() != 0);
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("dct_count", 32'(dct_count), 32'(m_acc.size()));
            chk("dct_buffer", 32'(dct_buffer), 32'(pack(m_acc)));
            chk("pkt_valid", 32'(pkt_valid), 32'(m_hv));
            if (m_hv) begin
                chk("pkt_count", 32'(pkt_count), 32'(m_pkt.size()));
                chk("pkt_data", 32'(pkt_data), 32'(pack(m_pkt)));
            end
            chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
            chk("overflow", 32'(overflow), 32'(m_ovf));
        end
    end

    task automatic tick(input bit sv, input logic [1:0] s, input bit fl, input bit rdy);
        sym_valid = sv; sym_in = s; flush = fl; pkt_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_count", 32'(dct_count), 0);
        chk("rst_buffer", 32'(dct_buffer), 0);
        chk("rst_pkt_valid", 32'(pkt_valid), 0);
        chk("rst_drop", 32'(drop_cnt), 0);
        reset_n = 1'b1;
        chk_en = 1'b1;

        // Full packet
        for (int i = 0; i < 15; i++) tick(1, 2'd1, 0, 1);
        chk("full_count", 32'(dct_count), 15);
        chk("full_buffer", 32'(dct_buffer), 32'h15555555);
        tick(0, 0, 0, 1);
        chk("full_pkt_valid", 32'(pkt_valid), 1);
        chk("full_pkt_count", 32'(pkt_count), 15);
        chk("full_pkt_data", 32'(pkt_data), 32'h15555555);
        chk("full_count_after", 32'(dct_count), 0);

        // Partial flush, symbols 3,2,1
        tick(1, 2'd3, 0, 1);
        tick(1, 2'd2, 0, 1);
        tick(1, 2'd1, 0, 1);
        tick(0, 0, 1, 1);
        chk("flush_not_yet", 32'(pkt_valid), 0);
        tick(0, 0, 0, 1);
        chk("flush_pkt_valid", 32'(pkt_valid), 1);
        chk("flush_pkt_count", 32'(pkt_count), 3);
        chk("flush_pkt_data", 32'(pkt_data), 32'h0000001B);

        // Partial flush with flush on the last symbol, symbols 3,1,2
        tick(1, 2'd3, 0, 1);
        tick(1, 2'd1, 0, 1);
        tick(1, 2'd2, 1, 1);
        tick(0, 0, 0, 1);
        chk("flush2_pkt_count", 32'(pkt_count), 3);
        chk("flush2_pkt_data", 32'(pkt_data), 32'h00000027);

        // Flush with nothing accumulated
        tick(0, 0, 1, 1);
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 1);
        chk("empty_flush_valid", 32'(pkt_valid), 0);

        // Backpressure and drops
        for (int i = 0; i < 15; i++) tick(1, 2'd2, 0, 0);
        tick(0, 0, 0, 0);
        chk("bp_held", 32'(pkt_valid), 1);
        for (int i = 0; i < 19; i++) tick(1, 2'(i % 4), 0, 0);
        chk("bp_count", 32'(dct_count), 15);
        chk("bp_drop", 32'(drop_cnt), 4);
        chk("bp_overflow", 32'(overflow), 1);
        chk("bp_buffer", 32'(dct_buffer), 32'h24E4E4E4);
        chk("bp_held_data", 32'(pkt_data), 32'h2AAAAAAA);
        tick(0, 0, 0, 1);
        chk("bp_relaunch_valid", 32'(pkt_valid), 1);
        chk("bp_relaunch_data", 32'(pkt_data), 32'h24E4E4E4);
        chk("bp_relaunch_count", 32'(dct_count), 0);
        chk("bp_overflow_off", 32'(overflow), 0);

        // Launch with a symbol in the same cycle
        for (int i = 0; i < 15; i++) tick(1, 2'd1, 0, 1);
        tick(1, 2'd3, 0, 1);
        chk("ls_pkt_valid", 32'(pkt_valid), 1);
        chk("ls_pkt_data", 32'(pkt_data), 32'h15555555);
        chk("ls_count", 32'(dct_count), 1);
        chk("ls_buffer", 32'(dct_buffer), 3);
        chk("ls_drop", 32'(drop_cnt), 4);
        tick(0, 0, 1, 1);
        tick(0, 0, 0, 1);
        chk("ls_tail_count", 32'(pkt_count), 1);
        tick(0, 0, 0, 1);

        // Idle timeout
        for (int i = 0; i < 5; i++) tick(1, 2'd2, 0, 1);
        for (int k = 1; k <= 70; k++) begin
            tick(0, 0, 0, 1);
`ifdef OCI_DCT_TIMEOUT_EN
            if (k == 64) chk("to_not_yet", 32'(pkt_valid), 0);
            if (k == 65) begin
                chk("to_pkt_valid", 32'(pkt_valid), 1);
                chk("to_pkt_count", 32'(pkt_count), 5);
            end
`endif
        end
`ifndef OCI_DCT_TIMEOUT_EN
        chk("no_to_valid", 32'(pkt_valid), 0);
        chk("no_to_count", 32'(dct_count), 5);
`endif
        tick(0, 0, 1, 1);
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 1);

        // Asynchronous reset mid-fill
        for (int i = 0; i < 7; i++) tick(1, 2'd3, 0, 1);
        reset_n = 1'b0;
        #1;
        chk("areset_count", 32'(dct_count), 0);
        chk("areset_buffer", 32'(dct_buffer), 0);
        chk("areset_pkt_valid", 32'(pkt_valid), 0);
        chk("areset_drop", 32'(drop_cnt), 0);
        #3;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Drop counter saturation
        for (int i = 0; i < 15; i++) tick(1, 2'd1, 0, 0);
        tick(0, 0, 0, 0);
        for (int i = 0; i < 275; i++) tick(1, 2'd2, 0, 0);
        chk("sat_drop", 32'(drop_cnt), 255);
        chk("sat_overflow", 32'(overflow), 1);
        tick(0, 0, 0, 1);
        chk("sat_hold", 32'(drop_cnt), 255);
        tick(0, 0, 0, 1);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
